// File: rtl/smpl_circ_queue.sv
// Dual-channel circular sample queue feeding the coefficient-ROM FIR stages.
// Each accepted sample, once READ_LEN are held, triggers a burst of the newest READ_LEN pairs, oldest first.
module smpl_circ_queue #(
  parameter int DEPTH    = 1024,
  parameter int READ_LEN = 1021,
  parameter int PTR_W    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrt_smpl,
  input  logic [15:0] lft_smpl,
  input  logic [15:0] rght_smpl,
  output logic [15:0] lft_out,
  output logic [15:0] rght_out,
  output logic        sequencing,
  output logic        full,
  output logic        overrun
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2
  } state_t;

  localparam logic [PTR_W-1:0] RL     = PTR_W'(READ_LEN);
  localparam logic [PTR_W-1:0] RL_M1  = PTR_W'(READ_LEN - 1);
  localparam logic [PTR_W-1:0] PTR_1  = PTR_W'(1);

  state_t           state_q, state_d;
  logic [PTR_W-1:0] new_ptr_q, new_ptr_d;
  logic [PTR_W-1:0] old_ptr_q, old_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] fill_q, fill_d;
  logic [PTR_W-1:0] rd_cnt_q, rd_cnt_d;
  logic             full_q, full_d;
  logic             ovr_q, ovr_d;
  logic             seq_q, seq_d;
  logic [15:0]      lft_q, lft_d;
  logic [15:0]      rght_q, rght_d;

  logic             wr_en;
  logic             rd_en;
  logic [PTR_W-1:0] rd_addr;
  logic [31:0]      rd_data_q;

  logic [31:0]      mem [DEPTH];

  // Storage has no reset so it maps onto block RAM; reads and writes are
  // confined to disjoint FSM states, so no same-address collision occurs.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[new_ptr_q] <= {lft_smpl, rght_smpl};
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  always_comb begin
    state_d   = state_q;
    new_ptr_d = new_ptr_q;
    old_ptr_d = old_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    fill_d    = fill_q;
    rd_cnt_d  = rd_cnt_q;
    full_d    = full_q;
    ovr_d     = ovr_q;
    seq_d     = 1'b0;
    lft_d     = lft_q;
    rght_d    = rght_q;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = rd_ptr_q;

    case (state_q)
      IDLE: begin
        if (wrt_smpl) begin
          wr_en     = 1'b1;
          new_ptr_d = new_ptr_q + PTR_1;
          // Once saturated, the oldest pointer trails the write pointer by READ_LEN.
          if (fill_q == RL) begin
            old_ptr_d = old_ptr_q + PTR_1;
          end else begin
            fill_d = fill_q + PTR_1;
          end
          if ((fill_q == RL) || (fill_q == RL_M1)) begin
            full_d  = 1'b1;
            state_d = PRIME;
          end
        end
      end

      PRIME: begin
        rd_en    = 1'b1;
        rd_addr  = old_ptr_q;
        rd_ptr_d = old_ptr_q + PTR_1;
        rd_cnt_d = '0;
        state_d  = STREAM;
      end

      STREAM: begin
        rd_en    = 1'b1;
        rd_addr  = rd_ptr_q;
        rd_ptr_d = rd_ptr_q + PTR_1;
        rd_cnt_d = rd_cnt_q + PTR_1;
        seq_d    = 1'b1;
        lft_d    = rd_data_q[31:16];
        rght_d   = rd_data_q[15:0];
        if (rd_cnt_q == RL_M1) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (wrt_smpl && (state_q != IDLE)) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      new_ptr_q <= '0;
      old_ptr_q <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= '0;
      rd_cnt_q  <= '0;
      full_q    <= 1'b0;
      ovr_q     <= 1'b0;
      seq_q     <= 1'b0;
      lft_q     <= '0;
      rght_q    <= '0;
    end else begin
      state_q   <= state_d;
      new_ptr_q <= new_ptr_d;
      old_ptr_q <= old_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fill_q    <= fill_d;
      rd_cnt_q  <= rd_cnt_d;
      full_q    <= full_d;
      ovr_q     <= ovr_d;
      seq_q     <= seq_d;
      lft_q     <= lft_d;
      rght_q    <= rght_d;
    end
  end

  assign lft_out    = lft_q;
  assign rght_out   = rght_q;
  assign sequencing = seq_q;
  assign full       = full_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_smpl_circ_queue.sv
// Scoreboard bench for smpl_circ_queue: a full-size instance and a small (DEPTH=8, READ_LEN=5) instance.
module tb_smpl_circ_queue;

  localparam int RLB = 1021;
  localparam int RLS = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_b, wrt_b, seq_b, full_b, ovr_b;
  logic [15:0] lft_b, rght_b, lo_b, ro_b;
  logic        rst_s, wrt_s, seq_s, full_s, ovr_s;
  logic [15:0] lft_s, rght_s, lo_s, ro_s;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_b[$];
  logic [31:0] exp_s[$];
  logic [31:0] hist_b[$];
  logic [31:0] hist_s[$];
  logic [31:0] e_b, e_s;

  smpl_circ_queue #(.DEPTH(1024), .READ_LEN(RLB), .PTR_W(10)) u_big (
    .clk(clk), .rst(rst_b), .wrt_smpl(wrt_b), .lft_smpl(lft_b), .rght_smpl(rght_b),
    .lft_out(lo_b), .rght_out(ro_b), .sequencing(seq_b), .full(full_b), .overrun(ovr_b)
  );

  smpl_circ_queue #(.DEPTH(8), .READ_LEN(RLS), .PTR_W(3)) u_small (
    .clk(clk), .rst(rst_s), .wrt_smpl(wrt_s), .lft_smpl(lft_s), .rght_smpl(rght_s),
    .lft_out(lo_s), .rght_out(ro_s), .sequencing(seq_s), .full(full_s), .overrun(ovr_s)
  );

  function automatic logic [31:0] pk(input logic [15:0] v);
    logic [15:0] n;
    n = -v;
    return {v, n};
  endfunction

  // Reference model: on each accepted sample, once READ_LEN are held, the
  // newest READ_LEN pairs (oldest first) become the expected burst.
  task automatic model_push(input bit sm, input logic [15:0] v);
    if (sm) begin
      hist_s.push_back(pk(v));
      if (hist_s.size() > RLS) void'(hist_s.pop_front());
      if (hist_s.size() == RLS) foreach (hist_s[k]) exp_s.push_back(hist_s[k]);
    end else begin
      hist_b.push_back(pk(v));
      if (hist_b.size() > RLB) void'(hist_b.pop_front());
      if (hist_b.size() == RLB) foreach (hist_b[k]) exp_b.push_back(hist_b[k]);
    end
  endtask

  task automatic wr(input bit sm, input logic [15:0] v, input bit acc);
    @(negedge clk);
    if (sm) begin lft_s = v; rght_s = -v; wrt_s = 1'b1; end
    else    begin lft_b = v; rght_b = -v; wrt_b = 1'b1; end
    @(negedge clk);
    wrt_s = 1'b0;
    wrt_b = 1'b0;
    if (acc) model_push(sm, v);
  endtask

  // Called right after wr(): index i counts negedges after the write edge.
  task automatic measure(input bit sm, output int first, output int len);
    logic s;
    int   lim;
    first = -1;
    len   = 0;
    lim   = (sm ? RLS : RLB) + 20;
    for (int i = 1; i <= lim; i++) begin
      @(negedge clk);
      s = sm ? seq_s : seq_b;
      if (s === 1'b1) begin
        if (first < 0) first = i;
        len++;
      end else if (first >= 0) begin
        break;
      end
    end
  endtask

  always @(negedge clk) begin
    if (seq_b === 1'b1) begin
      checks++;
      if (exp_b.size() == 0) begin
        errors++;
        $display("FAIL mon_big unexpected burst data got=%h required=none", {lo_b, ro_b});
      end else begin
        e_b = exp_b.pop_front();
        if ({lo_b, ro_b} !== e_b) begin
          errors++;
          $display("FAIL mon_big data got=%h required=%h", {lo_b, ro_b}, e_b);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (seq_s === 1'b1) begin
      checks++;
      if (exp_s.size() == 0) begin
        errors++;
        $display("FAIL mon_small unexpected burst data got=%h required=none", {lo_s, ro_s});
      end else begin
        e_s = exp_s.pop_front();
        if ({lo_s, ro_s} !== e_s) begin
          errors++;
          $display("FAIL mon_small data got=%h required=%h", {lo_s, ro_s}, e_s);
        end
      end
    end
  end

  task automatic test_reset();
    rst_b = 1'b1; rst_s = 1'b1;
    wrt_b = 1'b0; wrt_s = 1'b0;
    lft_b = '0; rght_b = '0; lft_s = '0; rght_s = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({seq_b, full_b, ovr_b, lo_b, ro_b} !== 35'd0) begin
      errors++;
      $display("FAIL reset_big got=%h required=0", {seq_b, full_b, ovr_b, lo_b, ro_b});
    end
    checks++;
    if ({seq_s, full_s, ovr_s, lo_s, ro_s} !== 35'd0) begin
      errors++;
      $display("FAIL reset_small got=%h required=0", {seq_s, full_s, ovr_s, lo_s, ro_s});
    end
    rst_b = 1'b0; rst_s = 1'b0;
    $display("reset released");
  endtask

  task automatic test_fill(input string tag);
    int highs;
    highs = 0;
    for (int v = 1; v <= RLB - 1; v++) begin
      wr(1'b0, 16'(v), 1'b1);
      if (seq_b === 1'b1) highs++;
    end
    checks++;
    if (highs != 0) begin
      errors++;
      $display("FAIL %s_no_burst got=%0d high samples required=0", tag, highs);
    end
    checks++;
    if (full_b !== 1'b0) begin
      errors++;
      $display("FAIL %s_full got=%b required=0", tag, full_b);
    end
    $display("%s: %0d writes, sequencing highs=%0d full=%b", tag, RLB - 1, highs, full_b);
  endtask

  task automatic test_burst_big(input logic [15:0] v, input string tag);
    int first, len;
    wr(1'b0, v, 1'b1);
    checks++;
    if (full_b !== 1'b1) begin
      errors++;
      $display("FAIL %s_full got=%b required=1", tag, full_b);
    end
    measure(1'b0, first, len);
    checks++;
    if (first != 2 || len != RLB) begin
      errors++;
      $display("FAIL %s_timing got first=%0d len=%0d required first=2 len=%0d", tag, first, len, RLB);
    end
    checks++;
    if ({lo_b, ro_b} !== pk(v) || exp_b.size() != 0) begin
      errors++;
      $display("FAIL %s_hold got=%h pending=%0d required=%h pending=0", tag, {lo_b, ro_b}, exp_b.size(), pk(v));
    end
    $display("%s: write %0d burst first=%0d len=%0d last=%0d", tag, v, first, len, lo_b);
  endtask

  task automatic test_overrun();
    int len;
    checks++;
    if (ovr_b !== 1'b0) begin
      errors++;
      $display("FAIL overrun_pre got=%b required=0", ovr_b);
    end
    wr(1'b0, 16'd1023, 1'b1);
    len = 0;
    for (int i = 1; i <= RLB + 20; i++) begin
      @(negedge clk);
      if (seq_b === 1'b1) len++;
      if (i == 100) begin lft_b = 16'h7777; rght_b = 16'h8889; wrt_b = 1'b1; end
      else wrt_b = 1'b0;
    end
    checks++;
    if (len != RLB || ovr_b !== 1'b1) begin
      errors++;
      $display("FAIL overrun_burst got len=%0d ovr=%b required len=%0d ovr=1", len, ovr_b, RLB);
    end
    test_burst_big(16'd1024, "post_overrun");
    checks++;
    if (ovr_b !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky got=%b required=1", ovr_b);
    end
    $display("overrun: burst len=%0d overrun=%b", len, ovr_b);
  endtask

  task automatic test_reset_mid();
    wr(1'b0, 16'd1025, 1'b1);
    repeat (50) @(negedge clk);
    #2 rst_b = 1'b1;
    #1;
    checks++;
    if ({seq_b, full_b, ovr_b, lo_b, ro_b} !== 35'd0) begin
      errors++;
      $display("FAIL reset_mid got=%h required=0", {seq_b, full_b, ovr_b, lo_b, ro_b});
    end
    exp_b.delete();
    hist_b.delete();
    @(negedge clk);
    rst_b = 1'b0;
    $display("reset mid-burst: outputs cleared");
    test_fill("refill");
    test_burst_big(16'd1021, "refill_burst");
  endtask

  task automatic test_small_bursts();
    int first, len;
    for (int i = 1; i <= 10; i++) begin
      wr(1'b1, 16'(10 * i), 1'b1);
      checks++;
      if (full_s !== (i >= RLS)) begin
        errors++;
        $display("FAIL small_full_%0d got=%b required=%b", i, full_s, (i >= RLS));
      end
      measure(1'b1, first, len);
      checks++;
      if ((i >= RLS) ? (first != 2 || len != RLS) : (len != 0)) begin
        errors++;
        $display("FAIL small_burst_%0d got first=%0d len=%0d", i, first, len);
      end
      $display("small write %0d: burst len=%0d last=%0d", 10 * i, len, lo_s);
    end
  endtask

  task automatic test_wrap();
    int first, len;
    for (int i = 0; i < 30; i++) begin
      wr(1'b1, 16'(200 + i), 1'b1);
      measure(1'b1, first, len);
      checks++;
      if (first != 2 || len != RLS || lo_s !== 16'(200 + i)) begin
        errors++;
        $display("FAIL wrap_%0d got first=%0d len=%0d last=%0d required 2/%0d/%0d", i, first, len, lo_s, RLS, 200 + i);
      end
    end
    $display("wrap: 30 bursts across pointer wrap");
  endtask

  task automatic test_back_to_back();
    int first, len;
    checks++;
    if (ovr_s !== 1'b0) begin
      errors++;
      $display("FAIL b2b_pre_overrun got=%b required=0", ovr_s);
    end
    @(negedge clk); lft_s = 16'd500; rght_s = -16'd500; wrt_s = 1'b1;
    @(negedge clk); lft_s = 16'd501; rght_s = -16'd501;
    model_push(1'b1, 16'd500);
    @(negedge clk); lft_s = 16'd502; rght_s = -16'd502;
    @(negedge clk); wrt_s = 1'b0;
    measure(1'b1, first, len);
    checks++;
    if (len != RLS - 1 || ovr_s !== 1'b1) begin
      errors++;
      $display("FAIL b2b_burst got len=%0d ovr=%b required len=%0d ovr=1", len, ovr_s, RLS - 1);
    end
    wr(1'b1, 16'd600, 1'b1);
    measure(1'b1, first, len);
    checks++;
    if (first != 2 || len != RLS) begin
      errors++;
      $display("FAIL b2b_next got first=%0d len=%0d required 2/%0d", first, len, RLS);
    end
    $display("back-to-back: overrun=%b next burst len=%0d", ovr_s, len);
  endtask

  initial begin
    test_reset();
    test_small_bursts();
    test_wrap();
    test_back_to_back();
    test_fill("fill");
    test_burst_big(16'd1021, "first_burst");
    test_burst_big(16'd1022, "second_burst");
    test_overrun();
    test_reset_mid();
    repeat (5) @(negedge clk);
    checks++;
    if (exp_b.size() != 0 || exp_s.size() != 0) begin
      errors++;
      $display("FAIL drain got pending big=%0d small=%0d required 0", exp_b.size(), exp_s.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
